// File: rtl/dmem_responder_pkg.sv
// Shared definitions for the data-memory responder: FSM state encodings,
// legal wait-state range and access classification helpers.
package dmem_responder_pkg;

  localparam logic [1:0] DMEM_IDLE = 2'd0;
  localparam logic [1:0] DMEM_WAIT = 2'd1;
  localparam logic [1:0] DMEM_RESP = 2'd2;

  localparam int DMEM_WS_MIN = 1;
  localparam int DMEM_WS_MAX = 15;

  // Byte offset inside the word must be zero for a legal word access.
  function automatic logic is_misaligned(input logic [1:0] addr_lo);
    return addr_lo != 2'b00;
  endfunction

  // A request is rejected when misaligned or when read and write collide.
  function automatic logic is_bad_access(input logic ren, input logic wen,
                                         input logic [1:0] addr_lo);
    return is_misaligned(addr_lo) || (ren && wen);
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// MEM-stage data-memory request/response bundle. The CPU side is the master,
// the responder is the slave.
interface dmem_responder_if;
  import dmem_responder_pkg::*;

  logic        mem_ren;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_dout;
  logic [31:0] mem_din;
  logic        mem_stall;
  logic        mem_err;

  modport master (
    output mem_ren, mem_wen, mem_addr, mem_dout,
    input  mem_din, mem_stall, mem_err
  );

  modport slave (
    input  mem_ren, mem_wen, mem_addr, mem_dout,
    output mem_din, mem_stall, mem_err
  );

endinterface

// File: rtl/dmem_responder_array.sv
// Word-addressed 2^ADDR_WIDTH x 32 storage. Synchronous write, synchronous
// registered read; the read register holds its value until the next read or
// a synchronous clear. Storage itself is never reset.
module dmem_array #(
  parameter int ADDR_WIDTH = 10
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic                  re,
  input  logic                  clr,
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  logic [31:0] mem [2**ADDR_WIDTH];

  // Write port: commit on the clock edge when enabled.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[addr] <= wdata;
    end
  end

  // Read register: clear wins over a read, otherwise hold.
  always_ff @(posedge clk) begin
    if (clr) begin
      rdata <= 32'h0;
    end else if (re) begin
      rdata <= mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder for the MEM stage. Holds the pipeline via mem_stall
// for WAIT_STATES cycles per access, then completes in a single RESP cycle.
// Optional feature macro: DMEM_ACCESS_CNT_EN adds saturating rd_count and
// wr_count outputs counting completed error-free reads and writes.
//
//   state | meaning
//   IDLE  | no access in flight; a request here is latched (stall is high)
//   WAIT  | access in flight, counter running, stall high
//   RESP  | completion cycle: read data / error valid, stall low
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int ADDR_WIDTH  = 10,
  parameter int WAIT_STATES = 2
) (
  input  logic           clk,
  input  logic           rst_n,
  dmem_responder_if.slave bus
`ifdef DMEM_ACCESS_CNT_EN
  ,
  output logic [31:0]    rd_count,
  output logic [31:0]    wr_count
`endif
);

  logic [1:0]            state;
  logic [3:0]            wait_cnt;
  logic [ADDR_WIDTH+1:0] addr_q;
  logic [31:0]           wdata_q;
  logic                  ren_q;
  logic                  wen_q;
  logic                  err_q;

  logic                  in_idle;
  logic                  req;
  logic                  cur_ren;
  logic                  cur_wen;
  logic [ADDR_WIDTH+1:0] cur_addr;
  logic [31:0]           cur_wdata;
  logic                  cur_bad;
  logic                  launch;
  logic                  arr_we;
  logic                  arr_re;
  logic                  arr_clr;
  logic [31:0]           arr_rdata;
  logic                  unused_addr_hi;

  assign in_idle = (state == DMEM_IDLE);
  assign req     = bus.mem_ren | bus.mem_wen;

  // With a single wait state the access launches straight out of IDLE, so
  // the live inputs are used there; otherwise the latched copy is used.
  assign cur_ren   = in_idle ? bus.mem_ren : ren_q;
  assign cur_wen   = in_idle ? bus.mem_wen : wen_q;
  assign cur_addr  = in_idle ? bus.mem_addr[ADDR_WIDTH+1:0] : addr_q;
  assign cur_wdata = in_idle ? bus.mem_dout : wdata_q;
  assign cur_bad   = is_bad_access(cur_ren, cur_wen, cur_addr[1:0]);

  // Upper address bits alias onto the array.
  assign unused_addr_hi = ^bus.mem_addr[31:ADDR_WIDTH+2];

  // launch marks the cycle whose closing edge enters RESP.
  assign launch = (in_idle && req && (WAIT_STATES == 1)) ||
                  ((state == DMEM_WAIT) && (wait_cnt == 4'd1));

  // Reset discards an in-flight write and clears the read register.
  assign arr_we  = rst_n && launch && cur_wen && !cur_bad;
  assign arr_re  = launch && cur_ren && !cur_bad;
  assign arr_clr = !rst_n || (launch && cur_ren && cur_bad);

  assign bus.mem_stall = (in_idle && req) || (state == DMEM_WAIT);
  assign bus.mem_err   = err_q;
  assign bus.mem_din   = arr_rdata;

  dmem_array #(.ADDR_WIDTH(ADDR_WIDTH)) u_array (
    .clk   (clk),
    .we    (arr_we),
    .re    (arr_re),
    .clr   (arr_clr),
    .addr  (cur_addr[ADDR_WIDTH+1:2]),
    .wdata (cur_wdata),
    .rdata (arr_rdata)
  );

  // Access sequencing: latch in IDLE, count down in WAIT, single RESP cycle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= DMEM_IDLE;
      wait_cnt <= 4'd0;
      addr_q   <= '0;
      wdata_q  <= 32'h0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      err_q <= launch && cur_bad;
      case (state)
        DMEM_IDLE: begin
          if (req) begin
            addr_q   <= bus.mem_addr[ADDR_WIDTH+1:0];
            wdata_q  <= bus.mem_dout;
            ren_q    <= bus.mem_ren;
            wen_q    <= bus.mem_wen;
            wait_cnt <= 4'(WAIT_STATES - 1);
            state    <= (WAIT_STATES == 1) ? DMEM_RESP : DMEM_WAIT;
          end
        end
        DMEM_WAIT: begin
          wait_cnt <= wait_cnt - 4'd1;
          if (wait_cnt == 4'd1) begin
            state <= DMEM_RESP;
          end
        end
        DMEM_RESP: begin
          state <= DMEM_IDLE;
        end
        default: begin
          state <= DMEM_IDLE;
        end
      endcase
    end
  end

`ifdef DMEM_ACCESS_CNT_EN
  // Count error-free completions as RESP retires; saturate at all-ones.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_count <= 32'h0;
      wr_count <= 32'h0;
    end else if ((state == DMEM_RESP) && !err_q) begin
      if (ren_q && (rd_count != 32'hFFFF_FFFF)) begin
        rd_count <= rd_count + 32'd1;
      end
      if (wen_q && (wr_count != 32'hFFFF_FFFF)) begin
        wr_count <= wr_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dmem_responder.sv
// Self-checking bench for dmem_responder: one instance with two wait states,
// one with a single wait state, checked against an array-based memory model.
module tb_dmem_responder;

  localparam int AW    = 10;
  localparam int WORDS = 1 << AW;

  logic clk;
  logic rst_n;

  int n_tests;
  int n_fail;

  logic [31:0] model_mem [2][WORDS];
  logic [31:0] model_din [2];
  int          model_rd  [2];
  int          model_wr  [2];
  int          ws        [2];

  dmem_responder_if if0();
  dmem_responder_if if1();

`ifdef DMEM_ACCESS_CNT_EN
  logic [31:0] rd_count0, wr_count0, rd_count1, wr_count1;
`endif

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(2)) dut0 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if0)
`ifdef DMEM_ACCESS_CNT_EN
    ,
    .rd_count (rd_count0),
    .wr_count (wr_count0)
`endif
  );

  dmem_responder #(.ADDR_WIDTH(AW), .WAIT_STATES(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (if1)
`ifdef DMEM_ACCESS_CNT_EN
    ,
    .rd_count (rd_count1),
    .wr_count (wr_count1)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] get_din(input int w);
    return (w == 0) ? if0.mem_din : if1.mem_din;
  endfunction

  function automatic logic get_stall(input int w);
    return (w == 0) ? if0.mem_stall : if1.mem_stall;
  endfunction

  function automatic logic get_err(input int w);
    return (w == 0) ? if0.mem_err : if1.mem_err;
  endfunction

  task automatic drive(input int w, input logic ren, input logic wen,
                       input logic [31:0] addr, input logic [31:0] data);
    if (w == 0) begin
      if0.mem_ren = ren; if0.mem_wen = wen; if0.mem_addr = addr; if0.mem_dout = data;
    end else begin
      if1.mem_ren = ren; if1.mem_wen = wen; if1.mem_addr = addr; if1.mem_dout = data;
    end
  endtask

  task automatic clear_models();
    for (int w = 0; w < 2; w++) begin
      model_din[w] = 32'h0;
      model_rd[w]  = 0;
      model_wr[w]  = 0;
    end
  endtask

  // One complete access: stall must be high for ws cycles, then a single
  // response cycle, then a quiet idle cycle with data held.
  task automatic do_access(input int w, input logic ren, input logic wen,
                           input logic [31:0] addr, input logic [31:0] wdata);
    int          idx;
    bit          bad;
    logic [31:0] exp_din;
    idx     = int'((addr >> 2) % WORDS);
    bad     = (addr % 4 != 0) || (ren && wen);
    exp_din = model_din[w];
    if (ren) exp_din = bad ? 32'h0 : model_mem[w][idx];

    @(negedge clk);
    drive(w, ren, wen, addr, wdata);
    #1;
    for (int k = 0; k < ws[w]; k++) begin
      check_val("stall_busy", 32'(get_stall(w)), 32'd1);
      @(negedge clk);
    end
    check_val("stall_resp", 32'(get_stall(w)), 32'd0);
    check_val("err_resp", 32'(get_err(w)), 32'(bad));
    check_val("din_resp", get_din(w), exp_din);
    drive(w, 1'b0, 1'b0, 32'h0, 32'h0);

    if (wen && !bad) model_mem[w][idx] = wdata;
    model_din[w] = exp_din;
    if (!bad && ren) model_rd[w]++;
    if (!bad && wen) model_wr[w]++;

    @(negedge clk);
    check_val("err_pulse_end", 32'(get_err(w)), 32'd0);
    check_val("stall_idle", 32'(get_stall(w)), 32'd0);
    check_val("din_hold", get_din(w), exp_din);
  endtask

  task automatic apply_reset();
    @(negedge clk);
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    repeat (2) @(negedge clk);
    clear_models();
    for (int w = 0; w < 2; w++) begin
      check_val("rst_stall", 32'(get_stall(w)), 32'd0);
      check_val("rst_err", 32'(get_err(w)), 32'd0);
      check_val("rst_din", get_din(w), 32'd0);
    end
    rst_n = 1'b1;
  endtask

  initial begin
    logic [31:0] addr;
    logic [31:0] pre_val;
    int          op;
    n_tests = 0;
    n_fail  = 0;
    ws[0]   = 2;
    ws[1]   = 1;
    rst_n   = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1, 1'b0, 1'b0, 32'h0, 32'h0);
    apply_reset();

    // Give every word used below a known value.
    for (int w = 0; w < 2; w++)
      for (int i = 0; i < 32; i++)
        do_access(w, 1'b0, 1'b1, 32'(i * 4), $urandom());

    // Write then read back through the two-wait-state instance.
    do_access(0, 1'b0, 1'b1, 32'h0000_0010, 32'hDEAD_BEEF);
    do_access(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);
    check_val("wr_rd_deadbeef", get_din(0), 32'hDEAD_BEEF);

    // Misaligned read, then word 4 still intact.
    do_access(0, 1'b1, 1'b0, 32'h0000_0013, 32'h0);
    do_access(0, 1'b1, 1'b0, 32'h0000_0010, 32'h0);

    // Read and write together: nothing written, data zeroed, error flagged.
    do_access(0, 1'b1, 1'b1, 32'h0000_0020, 32'h0000_1234);
    do_access(0, 1'b1, 1'b0, 32'h0000_0020, 32'h0);

    // Reset during the wait cycle of a write discards it.
    pre_val = model_mem[0][16];
    @(negedge clk);
    drive(0, 1'b0, 1'b1, 32'h0000_0040, 32'h0000_CAFE);
    @(negedge clk);
    check_val("mid_stall", 32'(get_stall(0)), 32'd1);
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(negedge clk);
    clear_models();
    check_val("midrst_stall", 32'(get_stall(0)), 32'd0);
    check_val("midrst_err", 32'(get_err(0)), 32'd0);
    check_val("midrst_din", get_din(0), 32'd0);
    rst_n = 1'b1;
    do_access(0, 1'b1, 1'b0, 32'h0000_0040, 32'h0);
    check_val("midrst_no_commit", get_din(0), pre_val);

    // Single wait state: 0x0 and 0x1000 alias the same word.
    do_access(1, 1'b0, 1'b1, 32'h0000_1000, 32'h5A5A_0001);
    do_access(1, 1'b1, 1'b0, 32'h0000_0000, 32'h0);
    check_val("alias_rd0", get_din(1), 32'h5A5A_0001);
    do_access(1, 1'b1, 1'b0, 32'h0000_1000, 32'h0);
    do_access(1, 1'b0, 1'b1, 32'h0000_0000, 32'h5A5A_0002);
    do_access(1, 1'b1, 1'b0, 32'h0000_1000, 32'h0);
    check_val("alias_rd1", get_din(1), 32'h5A5A_0002);

    // Randomized mix of reads, writes, collisions and misaligned accesses.
    for (int n = 0; n < 300; n++) begin
      int w;
      w    = int'($urandom_range(0, 1));
      op   = int'($urandom_range(0, 9));
      addr = ($urandom() & 32'hFFFF_F000) | (32'($urandom_range(0, 31)) << 2);
      if (op == 9) addr = addr | 32'($urandom_range(1, 3));
      case (op)
        0, 1, 2, 3: do_access(w, 1'b1, 1'b0, addr, 32'h0);
        4, 5, 6, 7: do_access(w, 1'b0, 1'b1, addr, $urandom());
        8:          do_access(w, 1'b1, 1'b1, addr, $urandom());
        default:    do_access(w, op[0], ~op[0] | $urandom_range(0, 1) == 1, addr, $urandom());
      endcase
    end

`ifdef DMEM_ACCESS_CNT_EN
    check_val("rd_count0_rand", rd_count0, 32'(model_rd[0]));
    check_val("wr_count0_rand", wr_count0, 32'(model_wr[0]));
    check_val("rd_count1_rand", rd_count1, 32'(model_rd[1]));
    check_val("wr_count1_rand", wr_count1, 32'(model_wr[1]));
    apply_reset();
    do_access(0, 1'b1, 1'b0, 32'h0000_0004, 32'h0);
    do_access(0, 1'b0, 1'b1, 32'h0000_0008, 32'h1111_2222);
    do_access(0, 1'b1, 1'b0, 32'h0000_0008, 32'h0);
    do_access(0, 1'b0, 1'b1, 32'h0000_0042, 32'h3333_4444);
    do_access(0, 1'b0, 1'b1, 32'h0000_000C, 32'h5555_6666);
    do_access(0, 1'b1, 1'b0, 32'h0000_000C, 32'h0);
    check_val("rd_count_3", rd_count0, 32'd3);
    check_val("wr_count_2", wr_count0, 32'd2);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
